// File: rtl/ps2_pkg.sv
// ----------------------------------------------------------------------------
// ps2_pkg
// Shared definitions for the PS/2 scan-code decoder slice.
//   - Scan-code set 2 prefix and device status byte constants
//   - Decoder FSM state encoding
//   - Key event record {brk, ext, code[7:0]} (10 bits)
//   - Small byte-classification helpers used by the decoder
// ----------------------------------------------------------------------------
package ps2_pkg;

    // Prefix bytes
    localparam logic [7:0] SC_EXT    = 8'hE0;
    localparam logic [7:0] SC_BRK    = 8'hF0;
    localparam logic [7:0] SC_PAUSE  = 8'hE1;

    // Device status bytes
    localparam logic [7:0] SC_BAT    = 8'hAA;
    localparam logic [7:0] SC_ACK    = 8'hFA;
    localparam logic [7:0] SC_RESEND = 8'hFE;
    localparam logic [7:0] SC_ERR0   = 8'h00;
    localparam logic [7:0] SC_ERR1   = 8'hFF;

    // Pause is E1 followed by seven more bytes; the counter is loaded on the E1
    localparam logic [2:0] PAUSE_SKIP = 3'd7;

    localparam int EVENT_W = 10;

    typedef struct packed {
        logic       brk;
        logic       ext;
        logic [7:0] code;
    } ps2_event_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_EXT,
        ST_BRK,
        ST_EXT_BRK,
        ST_PAUSE
    } dec_state_t;

    function automatic logic is_status(input logic [7:0] b);
        return (b == SC_BAT) || (b == SC_ACK) || (b == SC_RESEND) ||
               (b == SC_ERR0) || (b == SC_ERR1);
    endfunction

    function automatic logic is_prefix(input logic [7:0] b);
        return (b == SC_EXT) || (b == SC_BRK) || (b == SC_PAUSE);
    endfunction

endpackage

// File: rtl/ps2_scancode_decoder_if.sv
// ----------------------------------------------------------------------------
// ps2_scancode_decoder_if
// Bundles the byte input, key event handshake and status/overflow signals of
// the PS/2 scan-code decoder.
//   rx_ready/rx_data          : byte stream from the PS/2 receiver
//   ev_valid/ev_break/ev_ext/
//   ev_code/ev_ack            : show-ahead key event queue with valid/ack
//   status_pulse/status_code  : device status byte notification
//   overflow/ovf_clr          : sticky event-drop flag and its clear
// master = receiver + consumer side, slave = decoder.
// ----------------------------------------------------------------------------
interface ps2_scancode_decoder_if;

    logic       rx_ready;
    logic [7:0] rx_data;
    logic       ev_valid;
    logic       ev_break;
    logic       ev_ext;
    logic [7:0] ev_code;
    logic       ev_ack;
    logic       status_pulse;
    logic [7:0] status_code;
    logic       overflow;
    logic       ovf_clr;

    modport master (
        output rx_ready, rx_data, ev_ack, ovf_clr,
        input  ev_valid, ev_break, ev_ext, ev_code,
               status_pulse, status_code, overflow
    );

    modport slave (
        input  rx_ready, rx_data, ev_ack, ovf_clr,
        output ev_valid, ev_break, ev_ext, ev_code,
               status_pulse, status_code, overflow
    );

endinterface

// File: rtl/ps2_event_fifo.sv
// ----------------------------------------------------------------------------
// ps2_event_fifo
// Synchronous show-ahead FIFO of key event records.
//   clk, reset : clock and synchronous active-high reset (empties the queue)
//   push       : write push_data this cycle (accepted if not full, or if a
//                pop frees a slot in the same cycle)
//   push_data  : event record to enqueue
//   pop        : remove head this cycle (ignored when empty)
//   head       : current head record, zero while empty
//   full/empty : occupancy flags
// ----------------------------------------------------------------------------
module ps2_event_fifo
    import ps2_pkg::*;
#(
    parameter int FIFO_DEPTH = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       push,
    input  ps2_event_t push_data,
    input  logic       pop,
    output ps2_event_t head,
    output logic       full,
    output logic       empty
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] DEPTH_C = (AW + 1)'(FIFO_DEPTH);

    ps2_event_t    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          do_push;
    logic          do_pop;

    // A pop on an empty queue is meaningless; a push into a full queue only
    // lands when the same-cycle pop makes room for it.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    assign full  = (count == DEPTH_C);
    assign empty = (count == '0);
    assign head  = empty ? '0 : mem[rd_ptr];

    // Storage needs no reset: a slot is only visible after it was written.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointers wrap naturally because the depth is a power of two; the count
    // carries one extra bit so full and empty are distinguishable.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/ps2_scancode_decoder.sv
// ----------------------------------------------------------------------------
// ps2_scancode_decoder
// Turns the PS/2 set-2 byte stream into single key events (make/break,
// extended, Pause), queues them for a valid/ack consumer, and filters device
// status bytes into a separate pulse + held code.
//   clk    : system clock (receiver pulses already in this domain)
//   reset  : synchronous active-high reset; drops partial prefixes and the queue
//   bus    : ps2_scancode_decoder_if.slave
//            rx_ready/rx_data in, ev_* event queue head + ev_ack,
//            status_pulse/status_code, overflow/ovf_clr
// ----------------------------------------------------------------------------
module ps2_scancode_decoder
    import ps2_pkg::*;
#(
    parameter int FIFO_DEPTH = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    ps2_scancode_decoder_if.slave  bus
);

    dec_state_t state;
    dec_state_t next_state;
    logic [2:0] skip;
    logic [2:0] next_skip;
    logic       push;
    ps2_event_t push_rec;
    logic       status_hit;

    ps2_event_t head;
    logic       fifo_full;
    logic       fifo_empty;
    logic       pop;

    // Decoder state and Pause skip counter only move when the combinational
    // logic below decides so, which is only in rx_ready cycles.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
            skip  <= '0;
        end else begin
            state <= next_state;
            skip  <= next_skip;
        end
    end

    // Prefix tracking. A status byte aborts any pending prefix except inside
    // Pause, whose eight bytes are consumed blindly. Prefixes arriving after a
    // break prefix are protocol errors and are dropped without an event.
    always_comb begin
        next_state = state;
        next_skip  = skip;
        push       = 1'b0;
        push_rec   = '0;
        status_hit = 1'b0;
        if (bus.rx_ready) begin
            unique case (state)
                ST_IDLE: begin
                    if (bus.rx_data == SC_EXT) begin
                        next_state = ST_EXT;
                    end else if (bus.rx_data == SC_BRK) begin
                        next_state = ST_BRK;
                    end else if (bus.rx_data == SC_PAUSE) begin
                        next_state = ST_PAUSE;
                        next_skip  = PAUSE_SKIP;
                    end else if (is_status(bus.rx_data)) begin
                        status_hit = 1'b1;
                    end else begin
                        push     = 1'b1;
                        push_rec = '{brk: 1'b0, ext: 1'b0, code: bus.rx_data};
                    end
                end
                ST_EXT: begin
                    if (bus.rx_data == SC_BRK) begin
                        next_state = ST_EXT_BRK;
                    end else if (bus.rx_data == SC_EXT) begin
                        next_state = ST_EXT;
                    end else if (is_status(bus.rx_data)) begin
                        status_hit = 1'b1;
                        next_state = ST_IDLE;
                    end else begin
                        push       = 1'b1;
                        push_rec   = '{brk: 1'b0, ext: 1'b1, code: bus.rx_data};
                        next_state = ST_IDLE;
                    end
                end
                ST_BRK, ST_EXT_BRK: begin
                    next_state = ST_IDLE;
                    if (is_status(bus.rx_data)) begin
                        status_hit = 1'b1;
                    end else if (!is_prefix(bus.rx_data)) begin
                        push     = 1'b1;
                        push_rec = '{brk: 1'b1, ext: (state == ST_EXT_BRK),
                                     code: bus.rx_data};
                    end
                end
                ST_PAUSE: begin
                    if (skip <= 3'd1) begin
                        next_skip  = '0;
                        next_state = ST_IDLE;
                        push       = 1'b1;
                        push_rec   = '{brk: 1'b0, ext: 1'b1, code: SC_PAUSE};
                    end else begin
                        next_skip = skip - 1'b1;
                    end
                end
                default: begin
                    next_state = ST_IDLE;
                    next_skip  = '0;
                end
            endcase
        end
    end

    // Status notification: one-cycle pulse with the code held until the next
    // status byte arrives.
    always_ff @(posedge clk) begin
        if (reset) begin
            bus.status_pulse <= 1'b0;
            bus.status_code  <= '0;
        end else begin
            bus.status_pulse <= status_hit;
            if (status_hit) begin
                bus.status_code <= bus.rx_data;
            end
        end
    end

    assign pop = bus.ev_ack && !fifo_empty;

    ps2_event_fifo #(
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .push_data (push_rec),
        .pop       (pop),
        .head      (head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    // An event is lost only when the queue is full and nothing leaves it this
    // cycle. Setting takes priority over a simultaneous clear.
    always_ff @(posedge clk) begin
        if (reset) begin
            bus.overflow <= 1'b0;
        end else if (push && fifo_full && !pop) begin
            bus.overflow <= 1'b1;
        end else if (bus.ovf_clr) begin
            bus.overflow <= 1'b0;
        end
    end

    assign bus.ev_valid = !fifo_empty;
    assign bus.ev_break = head.brk;
    assign bus.ev_ext   = head.ext;
    assign bus.ev_code  = head.code;

endmodule

// File: tb/tb_ps2_scancode_decoder.sv
// ----------------------------------------------------------------------------
// tb_ps2_scancode_decoder
// Directed self-checking bench for ps2_scancode_decoder. Expected key events
// are pushed into a scoreboard queue as bytes are driven and popped when the
// DUT presents them at the head of its event queue.
// ----------------------------------------------------------------------------
module tb_ps2_scancode_decoder;
    import ps2_pkg::*;

    localparam int FIFO_DEPTH = 8;

    logic clk = 1'b0;
    logic reset = 1'b1;

    ps2_scancode_decoder_if bus ();

    ps2_scancode_decoder #(
        .FIFO_DEPTH (FIFO_DEPTH)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Free-running 100 MHz clock
    always #5 clk = ~clk;

    ps2_event_t sb[$];
    int         tests = 0;
    int         fails = 0;

    // Single comparison point: counts every check, reports and counts misses.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        tests++;
        assert (observed === expected)
        else begin
            fails++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Present one byte for the next rising edge; leaves rx_ready high so that
    // consecutive calls form back-to-back pulses. Called and returns at negedge.
    task automatic applyStimulus(input logic [7:0] b);
        bus.rx_ready = 1'b1;
        bus.rx_data  = b;
        @(negedge clk);
    endtask

    task automatic endBurst();
        bus.rx_ready = 1'b0;
        bus.rx_data  = 8'h00;
    endtask

    task automatic expectEvent(input logic brk, input logic ext, input logic [7:0] code);
        sb.push_back('{brk: brk, ext: ext, code: code});
    endtask

    // Compare the head against the oldest scoreboard entry, then acknowledge it.
    task automatic popAndCheck(input string tag);
        ps2_event_t exp_ev;
        exp_ev = (sb.size() > 0) ? sb.pop_front() : '0;
        checkOutput({tag, "_valid"}, 32'(bus.ev_valid), 32'(1));
        checkOutput({tag, "_head"}, 32'({bus.ev_break, bus.ev_ext, bus.ev_code}),
                    32'(exp_ev));
        bus.ev_ack = 1'b1;
        @(negedge clk);
        bus.ev_ack = 1'b0;
    endtask

    logic [7:0] pause_seq [8];

    initial begin
        pause_seq = '{8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77};
        bus.rx_ready = 1'b0;
        bus.rx_data  = 8'h00;
        bus.ev_ack   = 1'b0;
        bus.ovf_clr  = 1'b0;

        // Reset values
        repeat (3) @(negedge clk);
        reset = 1'b0;
        checkOutput("rst_ev_valid", 32'(bus.ev_valid), 32'(0));
        checkOutput("rst_ev_fields", 32'({bus.ev_break, bus.ev_ext, bus.ev_code}), 32'(0));
        checkOutput("rst_status_pulse", 32'(bus.status_pulse), 32'(0));
        checkOutput("rst_status_code", 32'(bus.status_code), 32'(0));
        checkOutput("rst_overflow", 32'(bus.overflow), 32'(0));

        // 1: plain make, then break
        applyStimulus(8'h1C);
        endBurst();
        expectEvent(1'b0, 1'b0, 8'h1C);
        popAndCheck("t1_make");
        applyStimulus(8'hF0);
        checkOutput("t1_prefix_quiet", 32'(bus.ev_valid), 32'(0));
        applyStimulus(8'h1C);
        endBurst();
        expectEvent(1'b1, 1'b0, 8'h1C);
        popAndCheck("t1_break");

        // 2: extended make and extended break
        applyStimulus(8'hE0);
        checkOutput("t2_e0_quiet", 32'(bus.ev_valid), 32'(0));
        applyStimulus(8'h75);
        endBurst();
        expectEvent(1'b0, 1'b1, 8'h75);
        popAndCheck("t2_ext_make");
        applyStimulus(8'hE0);
        applyStimulus(8'hF0);
        checkOutput("t2_e0f0_quiet", 32'(bus.ev_valid), 32'(0));
        applyStimulus(8'h75);
        endBurst();
        expectEvent(1'b1, 1'b1, 8'h75);
        popAndCheck("t2_ext_break");

        // 3: Pause sequence yields exactly one event after the eighth byte
        for (int i = 0; i < 8; i++) begin
            applyStimulus(pause_seq[i]);
            if (i < 7) begin
                checkOutput($sformatf("t3_quiet_%0d", i), 32'(bus.ev_valid), 32'(0));
            end
        end
        endBurst();
        expectEvent(1'b0, 1'b1, 8'hE1);
        popAndCheck("t3_pause");
        checkOutput("t3_single_event", 32'(bus.ev_valid), 32'(0));

        // 4: status filtering, including one that aborts a break prefix
        applyStimulus(8'hAA);
        endBurst();
        checkOutput("t4_bat_pulse", 32'(bus.status_pulse), 32'(1));
        checkOutput("t4_bat_code", 32'(bus.status_code), 32'hAA);
        @(negedge clk);
        checkOutput("t4_pulse_one_cycle", 32'(bus.status_pulse), 32'(0));
        applyStimulus(8'hF0);
        applyStimulus(8'hFA);
        checkOutput("t4_ack_pulse", 32'(bus.status_pulse), 32'(1));
        checkOutput("t4_ack_code", 32'(bus.status_code), 32'hFA);
        checkOutput("t4_no_key_event", 32'(bus.ev_valid), 32'(0));
        applyStimulus(8'h1C);
        endBurst();
        checkOutput("t4_pulse_cleared", 32'(bus.status_pulse), 32'(0));
        checkOutput("t4_code_held", 32'(bus.status_code), 32'hFA);
        expectEvent(1'b0, 1'b0, 8'h1C);
        popAndCheck("t4_make_after_status");

        // 5: fill past capacity, overflow, clear, full push+pop, set-wins
        for (int i = 0; i <= FIFO_DEPTH; i++) begin
            applyStimulus(8'h10 + 8'(i));
            if (i < FIFO_DEPTH) expectEvent(1'b0, 1'b0, 8'h10 + 8'(i));
        end
        endBurst();
        checkOutput("t5_overflow_set", 32'(bus.overflow), 32'(1));
        bus.ovf_clr = 1'b1;
        @(negedge clk);
        bus.ovf_clr = 1'b0;
        checkOutput("t5_overflow_clr", 32'(bus.overflow), 32'(0));
        checkOutput("t5_head_before", 32'(bus.ev_code), 32'(sb[0].code));
        bus.ev_ack = 1'b1;
        applyStimulus(8'h20);
        bus.ev_ack = 1'b0;
        endBurst();
        void'(sb.pop_front());
        expectEvent(1'b0, 1'b0, 8'h20);
        checkOutput("t5_full_pushpop_no_ovf", 32'(bus.overflow), 32'(0));
        checkOutput("t5_head_after", 32'(bus.ev_code), 32'(sb[0].code));
        bus.ovf_clr = 1'b1;
        applyStimulus(8'h21);
        bus.ovf_clr = 1'b0;
        endBurst();
        checkOutput("t5_set_wins", 32'(bus.overflow), 32'(1));
        bus.ovf_clr = 1'b1;
        @(negedge clk);
        bus.ovf_clr = 1'b0;
        checkOutput("t5_overflow_clr2", 32'(bus.overflow), 32'(0));
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            popAndCheck($sformatf("t5_drain_%0d", i));
        end
        checkOutput("t5_empty", 32'(bus.ev_valid), 32'(0));

        // Push with ack while empty: pop is ignored, the event stays queued
        bus.ev_ack = 1'b1;
        applyStimulus(8'h33);
        bus.ev_ack = 1'b0;
        endBurst();
        expectEvent(1'b0, 1'b0, 8'h33);
        popAndCheck("t5_empty_pushpop");

        // 6: reset mid-sequence drops queued events and partial prefixes
        applyStimulus(8'h1C);
        applyStimulus(8'hE0);
        applyStimulus(8'hF0);
        endBurst();
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        checkOutput("t6_queue_flushed", 32'(bus.ev_valid), 32'(0));
        checkOutput("t6_fields_zero", 32'({bus.ev_break, bus.ev_ext, bus.ev_code}), 32'(0));
        applyStimulus(8'h75);
        endBurst();
        expectEvent(1'b0, 1'b0, 8'h75);
        popAndCheck("t6_plain_after_reset");
        checkOutput("t6_empty", 32'(bus.ev_valid), 32'(0));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
